// File: rtl/oam_dma_engine.sv
// Sprite DMA engine: on a $4014 write, copies one CPU page (COUNT bytes) from RAM into OAM,
// holding busy high to stall the CPU for 1 + odd + 2*COUNT CPU cycles.
//
// state  | meaning
// IDLE   | waiting for a start strobe
// ALIGN0 | dummy cycle after the $4014 write
// ALIGN1 | extra alignment cycle when started on an odd CPU cycle
// READ   | present {page_r,count} to RAM
// WRITE  | RAM data valid; write it to OAM[count]
module oam_dma_engine #(
  parameter int COUNT     = 256,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 start,
  input  logic [7:0]           page,
  input  logic                 odd_cycle,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_read,
  output logic [ADDR_BITS-1:0] mem_address,
  input  logic [7:0]           mem_read_data,
  output logic                 oam_wren,
  output logic [7:0]           oam_address,
  output logic [7:0]           oam_write_data
);

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  typedef enum logic [2:0] {IDLE, ALIGN0, ALIGN1, READ, WRITE} state_t;

  state_t     state, state_nx;
  logic [7:0] count, count_nx;
  logic [7:0] page_r, page_nx;
  logic       odd_r, odd_nx;
  logic       done_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      page_r <= '0;
      odd_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      page_r <= page_nx;
      odd_r  <= odd_nx;
      busy   <= (state_nx != IDLE);
      done   <= done_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    count_nx       = count;
    page_nx        = page_r;
    odd_nx         = odd_r;
    done_nx        = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    oam_wren       = 1'b0;
    oam_address    = '0;
    oam_write_data = '0;
    case (state)
      IDLE: begin
        if (ce && start) begin
          page_nx  = page;
          odd_nx   = odd_cycle;
          count_nx = '0;
          state_nx = ALIGN0;
        end
      end
      ALIGN0: begin
        if (ce) state_nx = odd_r ? ALIGN1 : READ;
      end
      ALIGN1: begin
        if (ce) state_nx = READ;
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = ADDR_BITS'({page_r, count});
        if (ce) state_nx = WRITE;
      end
      WRITE: begin
        // RAM data was registered on the READ->WRITE edge and holds while ce is low
        oam_wren       = ce;
        oam_address    = count;
        oam_write_data = mem_read_data;
        if (ce) begin
          if (count == LAST) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            count_nx = count + 8'd1;
            state_nx = READ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
